// File: rtl/sram_controller_pkg.sv
// ----------------------------------------------------------------------------
// sram_controller_pkg
// Shared definitions for the SRAM controller slice:
//   - state_t            : access sequencer states
//   - DEFAULT_BASE_ADDR  : byte address that maps onto SRAM word 0
//   - DEFAULT_WAIT_CYCLES: clk cycles spent on each 16-bit half access
//   - DEFAULT_SRAM_AW    : SRAM address width in 16-bit words
//   - is_hi_half()       : true for the states that touch the upper halfword
// ----------------------------------------------------------------------------
package sram_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          DEFAULT_WAIT_CYCLES = 3;
    localparam int          DEFAULT_SRAM_AW     = 18;

    function automatic logic is_hi_half(input state_t s);
        return (s == RD_HI) || (s == WR_HI);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
// Counts the cycles spent in one half access, 0..WAIT_CYCLES-1, and flags the
// final one. The sequencer clears it on every state change so each half
// starts again from zero.
// Ports:
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   i_clear      in  load zero (asserted on the cycle before a state change)
//   i_en         in  advance the count this cycle
//   o_last_cycle out count has reached WAIT_CYCLES-1
// ----------------------------------------------------------------------------
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last_cycle
);

    localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            // Saturates at LAST; the sequencer always leaves the state there.
            r_count <= r_count + CW'(1);
        end
    end

    assign o_last_cycle = (r_count == LAST);

endmodule

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
// MEM-stage responder that turns each 32-bit load/store into two 16-bit
// accesses (low half first) to an external asynchronous SRAM, each half held
// for WAIT_CYCLES clocks. ready is low while an access is in flight so the
// pipeline freezes on ~ready.
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   rd_en, wr_en  load/store request levels, held while ready=0
//   addr          32-bit byte address (BASE_ADDR maps to SRAM word 0)
//   wr_data       32-bit store data
//   rd_data       32-bit load data, valid when ready=1 after a read
//   ready         1 = idle with no request, or access complete
//   sram_addr     SRAM 16-bit word address
//   sram_dq_in    SRAM data bus, read side
//   sram_dq_out   SRAM data bus, write side
//   sram_dq_oe    1 = drive sram_dq_out (tristate buffer sits above this)
//   sram_we_n     SRAM write strobe, active low
//   sram_oe_n     SRAM output enable, active low
// ----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int          SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    state_t               r_state;
    state_t               w_state_next;
    logic [SRAM_AW-2:0]   r_word;
    logic [31:0]          r_wdata;
    logic [15:0]          r_rd_half [2];
    logic                 w_last;
    logic                 w_busy;
    logic                 w_req;
    logic [SRAM_AW:0]     w_off;
    logic                 w_unused_bits;

    assign w_req = rd_en | wr_en;

    // Only the low SRAM_AW+1 bits of the offset survive the word mapping, and
    // those depend only on the low bits of the operands, so the subtraction
    // is done at that width. Higher address bits alias by construction.
    assign w_off         = addr[SRAM_AW:0] - BASE_ADDR[SRAM_AW:0];
    assign w_unused_bits = &{1'b0, addr[31:SRAM_AW+1], w_off[1:0]};

    // ------------------------------------------------------------------
    // Wait-state counter: runs only inside a half access, restarts on
    // every state transition.
    // ------------------------------------------------------------------
    assign w_busy = (r_state == RD_LO) || (r_state == RD_HI) ||
                    (r_state == WR_LO) || (r_state == WR_HI);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_state_next != r_state),
        .i_en         (w_busy),
        .o_last_cycle (w_last)
    );

    // ------------------------------------------------------------------
    // State register and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_req) begin
                r_word  <= w_off[SRAM_AW:2];
                r_wdata <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A write takes priority when both enables are set.
    // DONE always returns to IDLE, so a request still held is re-served.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (wr_en) begin
                    w_state_next = WR_LO;
                end else if (rd_en) begin
                    w_state_next = RD_LO;
                end
            end
            RD_LO:   if (w_last) w_state_next = RD_HI;
            RD_HI:   if (w_last) w_state_next = DONE;
            WR_LO:   if (w_last) w_state_next = WR_HI;
            WR_HI:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM strobes, decoded from registered state and count only.
    // we_n rises on the last cycle of each write half so address and data
    // are still stable when the SRAM latches on the rising edge of we_n.
    // ------------------------------------------------------------------
    always_comb begin
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
        case (r_state)
            RD_LO, RD_HI: begin
                sram_oe_n = 1'b0;
            end
            WR_LO: begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = r_wdata[15:0];
                sram_we_n   = w_last;
            end
            WR_HI: begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = r_wdata[31:16];
                sram_we_n   = w_last;
            end
            default: begin
                sram_oe_n = 1'b1;
            end
        endcase
    end

    assign sram_addr = {r_word, is_hi_half(r_state)};

    // ------------------------------------------------------------------
    // Read capture: each halfword is sampled on the last cycle of its read
    // half, giving the asynchronous SRAM the full wait window to settle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_half
            localparam state_t CAP_STATE = (gi == 0) ? RD_LO : RD_HI;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_half[gi] <= 16'h0000;
                end else if ((r_state == CAP_STATE) && w_last) begin
                    r_rd_half[gi] <= sram_dq_in;
                end
            end
        end
    endgenerate

    assign rd_data = {r_rd_half[1], r_rd_half[0]};
    assign ready   = ((r_state == IDLE) && !w_req) || (r_state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller
// Directed bench for sram_controller with a behavioural 16-bit asynchronous
// SRAM (combinational read, write while we_n is low with the bus driven).
// ----------------------------------------------------------------------------
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    // Behavioural SRAM; preload goes through the same process as writes.
    logic [15:0] mem [0:262143];
    logic        poke_en = 1'b0;
    logic [17:0] poke_addr = '0;
    logic [15:0] poke_data = '0;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (!sram_we_n && sram_dq_oe)
            mem[sram_addr] <= sram_dq_out;
    end

    assign sram_dq_in = mem[sram_addr];

    // Free-running monitors
    int cycle  = 0;
    int we_low = 0;
    int oe_low = 0;
    int viol   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!sram_we_n) we_low++;
        if (!sram_oe_n) oe_low++;
        if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic sram_poke(input logic [17:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    // Start a request on the next cycle and wait (bounded) for ready.
    // Returns with the request still asserted, at the negedge of the
    // ready cycle.
    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int we_cnt, output int oe_cnt);
        int we0;
        int oe0;
        @(posedge clk); #1;
        rd_en   = r;
        wr_en   = w;
        addr    = a;
        wr_data = d;
        we0     = we_low;
        oe0     = oe_low;
        lat     = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ready) begin
                lat = k;
                break;
            end
        end
        we_cnt = we_low - we0;
        oe_cnt = oe_low - oe0;
    endtask

    task automatic drop_req();
        @(posedge clk); #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    int lat;
    int we_cnt;
    int oe_cnt;
    int c1;
    int c2;
    int bad;

    initial begin
        rst     = 1'b1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = 32'd0;
        wr_data = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",   32'(ready),      32'd1);
        check("reset_rd_data", rd_data,         32'd0);
        check("reset_addr",    32'(sram_addr),  32'd0);
        check("reset_we_n",    32'(sram_we_n),  32'd1);
        check("reset_oe_n",    32'(sram_oe_n),  32'd1);
        check("reset_dq_oe",   32'(sram_dq_oe), 32'd0);

        sram_poke(18'd0, 16'h1234);
        sram_poke(18'd1, 16'hABCD);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle: no requests for 10 cycles
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!ready || !sram_we_n || !sram_oe_n || sram_dq_oe) bad++;
        end
        check("idle_10_cycles", 32'(bad), 32'd0);

        // Read 1024 -> SRAM[0..1]
        access(1'b1, 1'b0, 32'd1024, 32'd0, lat, we_cnt, oe_cnt);
        check("rd_latency", 32'(lat),    32'd7);
        check("rd_data",    rd_data,     32'hABCD1234);
        check("rd_oe_low",  32'(oe_cnt), 32'd6);
        check("rd_we_low",  32'(we_cnt), 32'd0);
        drop_req();

        // Write 1032 -> SRAM[4..5]
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, lat, we_cnt, oe_cnt);
        check("wr_latency",    32'(lat),    32'd7);
        check("wr_we_low",     32'(we_cnt), 32'd4);
        check("wr_oe_low",     32'(oe_cnt), 32'd0);
        check("wr_rd_data_kept", rd_data,   32'hABCD1234);
        drop_req();
        check("wr_mem4", 32'(mem[4]), 32'h0000BEEF);
        check("wr_mem5", 32'(mem[5]), 32'h0000DEAD);

        // Back-to-back: write 1040 then read 1040 with no idle gap
        access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, lat, we_cnt, oe_cnt);
        c1 = cycle;
        access(1'b1, 1'b0, 32'd1040, 32'd0, lat, we_cnt, oe_cnt);
        c2 = cycle;
        check("b2b_ready_gap", 32'(c2 - c1), 32'd8);
        check("b2b_rd_data",   rd_data,      32'h0BADF00D);
        drop_req();
        check("b2b_mem8", 32'(mem[8]), 32'h0000F00D);
        check("b2b_mem9", 32'(mem[9]), 32'h00000BAD);

        // Both enables: write wins, 1048 -> SRAM[12..13]
        access(1'b1, 1'b1, 32'd1048, 32'h55AA55AA, lat, we_cnt, oe_cnt);
        check("both_latency",     32'(lat),    32'd7);
        check("both_oe_low",      32'(oe_cnt), 32'd0);
        check("both_we_low",      32'(we_cnt), 32'd4);
        check("both_rd_data_kept", rd_data,    32'h0BADF00D);
        drop_req();
        check("both_mem12", 32'(mem[12]), 32'h000055AA);
        check("both_mem13", 32'(mem[13]), 32'h000055AA);

        // Aliasing: +2^19 bytes and byte offset 3 still land on word 0
        access(1'b1, 1'b0, 32'd1024 + 32'h0008_0000 + 32'd3, 32'd0, lat, we_cnt, oe_cnt);
        check("alias_latency", 32'(lat), 32'd7);
        check("alias_rd_data", rd_data,  32'hABCD1234);
        drop_req();

        // Reset during RD_HI of a read at 1024
        @(posedge clk); #1;
        rd_en = 1'b1;
        addr  = 32'd1024;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_rd_hi_addr", 32'(sram_addr), 32'd1);
        check("mid_rd_hi_oe_n", 32'(sram_oe_n), 32'd0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rd_data", rd_data,         32'd0);
        check("rst_mid_oe_n",    32'(sram_oe_n),  32'd1);
        check("rst_mid_we_n",    32'(sram_we_n),  32'd1);
        check("rst_mid_dq_oe",   32'(sram_dq_oe), 32'd0);
        check("rst_mid_ready_req", 32'(ready),    32'd0);
        #1;
        rd_en = 1'b0;
        #1;
        check("rst_mid_ready_idle", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        check("strobe_exclusive", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
